// File: rtl/uart_pkg.sv
// Shared UART definitions: register word offsets, STATUS bit
// positions, TX/RX FSM encodings and the minimum bit period.
package uart_pkg;

  localparam logic [1:0] REG_DIV    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  function automatic logic [15:0] eff_div(
    input logic [15:0] d
  );
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received UART data.
// Ports: clk, rst, push/din, pop/dout, full, empty.
module uart_rx_fifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [1<<AW];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH);
  assign do_pop  = pop && !empty;
  // a pop frees a slot in the same cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;

  always_ff @(posedge clk)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
    end

endmodule

// File: rtl/iomem_uart.sv
// iomem-bus UART slave: DIV/DATA/STATUS registers, 8N1 TX and RX.
// Ports: clk, rst, iomem_valid/ready/addr/rdata/wdata/wstrb,
// uart_tx, uart_rx. Define UART_RX_FIFO_EN for an RX FIFO of
// 2**RX_FIFO_AW bytes instead of a single holding register.
module iomem_uart
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0300_0000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int          RX_FIFO_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [31:0] iomem_addr,
  output logic [31:0] iomem_rdata,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic        sel, ready_q, is_wr, wr, rd, stall;
  logic [1:0]  reg_idx;
  logic [15:0] div_q, eff;
  logic        ovr_q, ferr_q;
  logic [3:0]  status;

  tx_state_e   tx_q, tx_d;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_go, tx_tick, tx_busy;

  rx_state_e   rx_q, rx_d;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_fall, rx_tick;
  logic        rx_push, rx_ferr;
  logic        rx_avail, rx_full, rx_pop;
  logic [7:0]  rx_head;

  logic        unused_ok;
  assign unused_ok = ^{iomem_addr[1:0],
                       iomem_wdata[31:16],
                       iomem_wstrb[3:2]};

  // bus decode; register actions happen in the ack cycle
  assign sel     = iomem_valid &&
                   (iomem_addr[31:4] == BASE[31:4]);
  assign reg_idx = iomem_addr[3:2];
  assign is_wr   = (iomem_wstrb != 4'b0);
  assign wr      = ready_q && sel && is_wr;
  assign rd      = ready_q && sel && !is_wr;
  // a TX byte is only taken once the previous frame is done
  assign stall   = is_wr && (reg_idx == REG_DATA) && tx_busy;

  always_ff @(posedge clk)
    if (rst) ready_q <= 1'b0;
    else     ready_q <= sel && !ready_q && !stall;

  assign iomem_ready = ready_q;

  always_ff @(posedge clk)
    if (rst) begin
      div_q <= DEFAULT_DIV;
    end else if (wr && reg_idx == REG_DIV) begin
      if (iomem_wstrb[0]) div_q[7:0]  <= iomem_wdata[7:0];
      if (iomem_wstrb[1]) div_q[15:8] <= iomem_wdata[15:8];
    end

  assign eff = eff_div(div_q);

  // ---------------- TX ----------------
  assign tx_go   = wr && (reg_idx == REG_DATA);
  assign tx_tick = (tx_cnt == 16'd0);

  always_ff @(posedge clk)
    if (rst) tx_q <= TX_IDLE;
    else     tx_q <= tx_d;

  always_comb begin
    tx_d = tx_q;
    unique case (tx_q)
      TX_IDLE:  if (tx_go) tx_d = TX_START;
      TX_START: if (tx_tick) tx_d = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7)
                  tx_d = TX_STOP;
      TX_STOP:  if (tx_tick) tx_d = TX_IDLE;
      default:  tx_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = (tx_q != TX_IDLE);
    uart_tx = 1'b1;
    unique case (tx_q)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_sh[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // period reloads at every bit start, so DIV edits land
  // on the next bit boundary
  always_ff @(posedge clk)
    if (rst) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_q == TX_IDLE) begin
      tx_cnt <= eff - 16'd1;
      tx_bit <= '0;
      tx_sh  <= iomem_wdata[7:0];
    end else if (tx_tick) begin
      tx_cnt <= eff - 16'd1;
      if (tx_q == TX_DATA) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
    end else begin
      tx_cnt <= tx_cnt - 16'd1;
    end

  // ---------------- RX ----------------
  always_ff @(posedge clk)
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end

  assign rx_fall = rx_s3 && !rx_s2;
  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk)
    if (rst) rx_q <= RX_IDLE;
    else     rx_q <= rx_d;

  always_comb begin
    rx_d = rx_q;
    unique case (rx_q)
      RX_IDLE:  if (rx_fall) rx_d = RX_START;
      RX_START: if (rx_tick)
                  rx_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7)
                  rx_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_d = RX_IDLE;
      default:  rx_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_q == RX_STOP) && rx_tick && rx_s2;
    rx_ferr = (rx_q == RX_STOP) && rx_tick && !rx_s2;
  end

  // idle preloads a half period to land mid start bit
  always_ff @(posedge clk)
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (rx_q == RX_IDLE) begin
      rx_cnt <= (eff >> 1) - 16'd1;
      rx_bit <= '0;
    end else if (rx_tick) begin
      rx_cnt <= eff - 16'd1;
      if (rx_q == RX_DATA) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - 16'd1;
    end

  assign rx_pop = rd && (reg_idx == REG_DATA) && rx_avail;

`ifdef UART_RX_FIFO_EN
  logic rx_empty;

  uart_rx_fifo #(
    .AW (RX_FIFO_AW),
    .W  (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_sh),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign rx_avail = !rx_empty;
`else
  logic       hold_v;
  logic [7:0] hold_q;
  logic       unused_cfg;

  assign unused_cfg = (RX_FIFO_AW > 0);

  always_ff @(posedge clk)
    if (rst) begin
      hold_v <= 1'b0;
      hold_q <= '0;
    end else if (rx_push && (!hold_v || rx_pop)) begin
      hold_v <= 1'b1;
      hold_q <= rx_sh;
    end else if (rx_pop) begin
      hold_v <= 1'b0;
    end

  assign rx_full  = hold_v;
  assign rx_avail = hold_v;
  assign rx_head  = hold_q;
`endif

  // new events win over a same-cycle clear
  always_ff @(posedge clk)
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_STATUS && iomem_wstrb[0]) begin
        if (iomem_wdata[ST_OVERRUN])   ovr_q  <= 1'b0;
        if (iomem_wdata[ST_FRAME_ERR]) ferr_q <= 1'b0;
      end
      if (rx_push && rx_full && !rx_pop) ovr_q <= 1'b1;
      if (rx_ferr) ferr_q <= 1'b1;
    end

  always_comb begin
    status               = '0;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_RX_AVAIL]  = rx_avail;
    status[ST_OVERRUN]   = ovr_q;
    status[ST_FRAME_ERR] = ferr_q;
  end

  always_comb begin
    iomem_rdata = 32'h0;
    if (ready_q && sel) begin
      unique case (reg_idx)
        REG_DIV:    iomem_rdata = {16'h0, div_q};
        REG_DATA:   iomem_rdata = rx_avail ?
                      {24'h0, rx_head} : 32'hFFFF_FFFF;
        REG_STATUS: iomem_rdata = {28'h0, status};
        default:    iomem_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_uart.sv
// Self-checking bench for iomem_uart: register vectors, serial
// TX/RX frames against a queue/waveform model, corner sequences.
module tb_iomem_uart;

  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_rdata;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic        uart_tx;
  logic        uart_rx;

  int total  = 0;
  int passed = 0;

  logic [31:0] r;
  int          l, e, e2, lat2;

  always #5 clk = ~clk;

  iomem_uart #(
    .BASE        (BASE),
    .DEFAULT_DIV (16'd104),
    .RX_FIFO_AW  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_rdata (iomem_rdata),
    .iomem_wdata (iomem_wdata),
    .iomem_wstrb (iomem_wstrb),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx)
  );

  typedef struct {
    logic [3:0]  off;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic bus(input logic [3:0] off,
                     input logic [31:0] d,
                     input logic [3:0] s,
                     output logic [31:0] rd,
                     output int lat);
    iomem_addr  = BASE + {28'h0, off};
    iomem_wdata = d;
    iomem_wstrb = s;
    iomem_valid = 1'b1;
    lat = 0;
    rd  = 32'h0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (iomem_ready) begin
        rd = iomem_rdata;
        break;
      end
      if (lat > 4000) begin
        total++;
        $display("FAIL bus_timeout off=%h: got no ready expected ready", off);
        lat = -1;
        break;
      end
    end
    @(posedge clk);
    #1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic rd_chk(input logic [3:0] off,
                        input logic [31:0] exp,
                        input string nm);
    logic [31:0] v;
    int          t;
    bus(off, 32'h0, 4'h0, v, t);
    check(nm, v, exp);
  endtask

  task automatic wr(input logic [3:0] off,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] v;
    int          t;
    bus(off, d, s, v, t);
  endtask

  // expected line level i cycles after the start edge
  function automatic logic tx_model(input logic [7:0] b,
                                    input int p, input int i);
    int k;
    k = i / p;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic cap(input logic [7:0] b, input int p,
                     output int errs);
    int w;
    errs = 0;
    w = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        errs = 9999;
        return;
      end
    end
    for (int i = 0; i < 10 * p; i++) begin
      if (uart_tx !== tx_model(b, p, i)) errs++;
      if (i != 10 * p - 1) @(negedge clk);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input int p,
                         input bit good_stop);
    logic [9:0] f;
    f = {good_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (p) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (2 * p) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rp;
    bit         bad;
    int         lows;

    iomem_valid = 1'b0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    iomem_wstrb = 4'h0;
    uart_rx     = 1'b1;

    tbl[0]  = '{4'h0, 32'h0,        4'h0, 32'h68};
    tbl[1]  = '{4'h8, 32'h0,        4'h0, 32'h0};
    tbl[2]  = '{4'h4, 32'h0,        4'h0, 32'hFFFF_FFFF};
    tbl[3]  = '{4'hC, 32'h0,        4'h0, 32'h0};
    tbl[4]  = '{4'h0, 32'h1234_5678, 4'h1, 32'h0};
    tbl[5]  = '{4'h0, 32'h0,        4'h0, 32'h78};
    tbl[6]  = '{4'h0, 32'h0000_ABCD, 4'h2, 32'h0};
    tbl[7]  = '{4'h0, 32'h0,        4'h0, 32'hAB78};
    tbl[8]  = '{4'h0, 32'hFFFF_0003, 4'hF, 32'h0};
    tbl[9]  = '{4'h0, 32'h0,        4'h0, 32'h3};
    tbl[10] = '{4'h8, 32'hF,        4'hF, 32'h0};
    tbl[11] = '{4'h8, 32'h0,        4'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset outputs",
          {uart_tx, iomem_ready, iomem_rdata[29:0]},
          32'h8000_0000);

    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].off, tbl[i].wd, tbl[i].st, r, l);
      check($sformatf("vec%0d ack latency", i), l, 1);
      if (tbl[i].st == 4'h0)
        check($sformatf("vec%0d rdata", i), r, tbl[i].exp);
    end

    // held request: ack pulses once, then drops
    iomem_addr  = BASE;
    iomem_wstrb = 4'h0;
    iomem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rp[2-i] = iomem_ready;
    end
    iomem_valid = 1'b0;
    @(posedge clk);
    #1;
    check("held request ready pattern", rp, 3'b010);

    // other slaves' windows are ignored
    bad = 0;
    iomem_addr  = BASE + 32'h10;
    iomem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (iomem_ready || iomem_rdata != 0) bad = 1;
    end
    iomem_addr = 32'h0200_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (iomem_ready || iomem_rdata != 0) bad = 1;
    end
    iomem_valid = 1'b0;
    @(posedge clk);
    #1;
    check("unselected silent", bad, 0);

    // DIV=8, byte 0x55
    wr(4'h0, 32'd8, 4'h3);
    fork
      begin
        bus(4'h4, 32'h55, 4'h1, r, l);
        rd_chk(4'h8, 32'h1, "status busy mid frame");
      end
      cap(8'h55, 8, e);
    join
    check("tx 0x55 waveform", e, 0);
    rd_chk(4'h8, 32'h0, "status idle after frame");

    // second DATA write stalls behind the first frame
    fork
      begin
        bus(4'h4, 32'hA5, 4'h1, r, l);
        bus(4'h4, 32'h3C, 4'h1, r, lat2);
      end
      begin
        cap(8'hA5, 8, e);
        cap(8'h3C, 8, e2);
      end
    join
    check("b2b frame A5", e, 0);
    check("b2b frame 3C", e2, 0);
    check("b2b second write stalled", lat2 >= 70, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int         d, p;
      logic [7:0] b;
      d = (t == 0) ? 2 : int'($urandom_range(0, 12));
      p = (d < 4) ? 4 : d;
      b = 8'($urandom_range(0, 255));
      wr(4'h0, 32'(d), 4'h3);
      fork
        bus(4'h4, {24'h0, b}, 4'h1, r, l);
        cap(b, p, e);
      join
      check($sformatf("rnd tx div=%0d byte=%h", d, b), e, 0);
    end

    // RX at DIV=16
    wr(4'h0, 32'd16, 4'h3);
    rx_send(8'hC3, 16, 1'b1);
    rd_chk(4'h8, 32'h2, "rx status avail");
    rd_chk(4'h4, 32'hC3, "rx data C3");
    rd_chk(4'h4, 32'hFFFF_FFFF, "rx data empty");

    rx_send(8'h11, 16, 1'b0);
    rd_chk(4'h8, 32'h8, "rx frame error");
    wr(4'h8, 32'h8, 4'h1);
    rd_chk(4'h8, 32'h0, "frame error cleared");

    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd_chk(4'h8, 32'h0, "rx glitch ignored");

    for (int i = 0; i <= CAP; i++)
      rx_send(8'(i + 1), 16, 1'b1);
    rd_chk(4'h8, 32'h6, "overrun status");
    for (int i = 0; i < CAP; i++)
      rd_chk(4'h4, 32'(i + 1), $sformatf("overrun kept %0d", i));
    rd_chk(4'h4, 32'hFFFF_FFFF, "overrun drained");
    wr(4'h8, 32'h4, 4'h1);
    rd_chk(4'h8, 32'h0, "overrun cleared");

    for (int t = 0; t < 6; t++) begin
      int         p, n;
      logic [7:0] q[$];
      bit         mo, mf;
      p  = int'($urandom_range(4, 20));
      n  = int'($urandom_range(1, CAP + 2));
      mo = 0;
      mf = 0;
      q.delete();
      wr(4'h0, 32'(p), 4'h3);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        bit         good;
        b    = 8'($urandom_range(0, 255));
        good = ($urandom_range(0, 3) != 0);
        rx_send(b, p, good);
        if (!good)                mf = 1;
        else if (q.size() >= CAP) mo = 1;
        else                      q.push_back(b);
      end
      rd_chk(4'h8, {28'h0, mf, mo, q.size() != 0, 1'b0},
             $sformatf("rnd rx status div=%0d", p));
      while (q.size() != 0)
        rd_chk(4'h4, {24'h0, q.pop_front()}, "rnd rx data");
      rd_chk(4'h4, 32'hFFFF_FFFF, "rnd rx empty");
      wr(4'h8, 32'hC, 4'h1);
    end

    // reset in the middle of a frame
    wr(4'h0, 32'd8, 4'h3);
    wr(4'h4, 32'h00, 4'h1);
    repeat (30) @(posedge clk);
    #1;
    check("tx low before reset", uart_tx, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("tx high after reset", uart_tx, 1'b1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    @(posedge clk);
    #1;
    check("tx stays idle after reset", lows, 0);
    rd_chk(4'h0, 32'h68, "div after reset");
    rd_chk(4'h8, 32'h0, "status after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
